// File: rtl/montgomery_precompute_if.sv
// Bundles the request/result signals between the requester (master) and the
// Montgomery constant precompute block (slave).
//   start        : single-cycle request, sampled only while idle
//   modulus      : odd modulus m, latched on an accepted start
//   busy         : high while a computation (or its done cycle) is in flight
//   done         : one-cycle completion pulse, also used for rejections
//   error        : valid with done, set when m is even or equal to 1
//   rmodm        : 2^N mod m
//   rsquaredmodm : 2^(2N) mod m
interface montgomery_precompute_if #(
    parameter int N = 512
);
    logic         start;
    logic [N-1:0] modulus;
    logic         busy;
    logic         done;
    logic         error;
    logic [N-1:0] rmodm;
    logic [N-1:0] rsquaredmodm;

    modport master (
        output start, modulus,
        input  busy, done, error, rmodm, rsquaredmodm
    );

    modport slave (
        input  start, modulus,
        output busy, done, error, rmodm, rsquaredmodm
    );
endinterface

// File: rtl/montgomery_precompute.sv
// Computes R mod m and R^2 mod m (R = 2^N) by repeated modular doubling,
// one doubling per clock, for the downstream exponentiation stage. Results
// hold until the next accepted start.
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset
//   bus   : request/result bundle (slave side)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; outputs hold the last results
// ST_RUN  | one modular doubling per cycle, 2N cycles in total
// ST_DONE | one-cycle done pulse (normal finish or rejected modulus)
module montgomery_precompute #(
    parameter int N = 512
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    montgomery_precompute_if.slave    bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam int CW = $clog2(2 * N) + 1;
    localparam logic [CW-1:0] CNT_R  = CW'(N - 1);
    localparam logic [CW-1:0] CNT_R2 = CW'(2 * N - 1);

    state_t        state_q;
    logic [N-1:0]  m_q;
    logic [N-1:0]  v_q;
    logic [N-1:0]  rmodm_q;
    logic [N-1:0]  r2_q;
    logic [CW-1:0] cnt_q;
    logic          error_q;
    logic          done_q;

    logic [N:0]    dbl;
    logic          geq;
    logic [N-1:0]  v_d;

    // v < m holds, so 2v < 2m and a single conditional subtract reduces it.
    // The compare needs the full N+1-bit doubled value; the subtract can be
    // done modulo 2^N because the true result is below m < 2^N.
    always_comb begin
        dbl = {v_q, 1'b0};
        geq = (dbl >= {1'b0, m_q});
        v_d = {v_q[N-2:0], 1'b0} - (geq ? m_q : '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            v_q     <= '0;
            rmodm_q <= '0;
            r2_q    <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        m_q <= bus.modulus;
                        if (!bus.modulus[0] || bus.modulus == N'(1)) begin
                            error_q <= 1'b1;
                            rmodm_q <= '0;
                            r2_q    <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            v_q     <= N'(1);
                            cnt_q   <= '0;
                            error_q <= 1'b0;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    v_q   <= v_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_R) begin
                        rmodm_q <= v_d;
                    end
                    if (cnt_q == CNT_R2) begin
                        r2_q    <= v_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.rmodm        = rmodm_q;
    assign bus.rsquaredmodm = r2_q;
endmodule

// File: tb/tb_montgomery_precompute.sv
// Bench for montgomery_precompute at N = 512: directed moduli with known
// constants, rejection cases, start-while-busy, continuous start, an
// asynchronous reset mid-run, and a few random odd moduli checked against
// a big-integer remainder model.
module tb_montgomery_precompute;
    localparam int N = 512;

    typedef struct {
        logic         err;
        logic [N-1:0] r;
        logic [N-1:0] r2;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    montgomery_precompute_if #(.N(N)) bus ();

    montgomery_precompute #(.N(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // 2^k mod m, via a wide remainder rather than iterated doubling.
    function automatic logic [N-1:0] pow2mod(input logic [N-1:0] m, input int k);
        logic [2*N:0] big;
        logic [2*N:0] mw;
        big    = '0;
        big[k] = 1'b1;
        mw     = {{(N+1){1'b0}}, m};
        big    = big % mw;
        return big[N-1:0];
    endfunction

    // Monitor: every done pulse consumes one expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 want no done");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("error", N'(bus.error), N'(e.err));
                chk("rmodm", bus.rmodm, e.r);
                chk("rsquaredmodm", bus.rsquaredmodm, e.r2);
            end
        end
    end

    // Issue one request, optionally poke a second start at cycle `poke`
    // while busy, and check latency and busy duration.
    task automatic run(input logic [N-1:0] m, input logic e,
                       input logic [N-1:0] r, input logic [N-1:0] r2,
                       input int poke);
        int cyc;
        int bcnt;
        int lat;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.modulus = m;
        sb_q.push_back('{e, r, r2});
        @(negedge clk);
        bus.start = 1'b0;
        cyc  = 1;
        bcnt = 0;
        lat  = e ? 1 : 2 * N + 1;
        while (!bus.done && cyc < 2 * N + 20) begin
            if (bus.busy) bcnt++;
            if (cyc == poke) begin
                bus.start   = 1'b1;
                bus.modulus = N'(11);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        if (bus.busy) bcnt++;
        chk("latency", N'(cyc), N'(lat));
        chk("busy_cycles", N'(bcnt), N'(lat));
        @(negedge clk);
        chk("busy_after_done", N'(bus.busy), N'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] mm;
        logic [N-1:0] rr;
        int           cyc;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.modulus = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", N'(bus.busy), N'(0));
        chk("rst_done", N'(bus.done), N'(0));
        chk("rst_error", N'(bus.error), N'(0));
        chk("rst_rmodm", bus.rmodm, '0);
        chk("rst_r2", bus.rsquaredmodm, '0);
        rst = 1'b0;

        // Small moduli with hand-computed constants.
        run(N'(13), 1'b0, N'(9), N'(3), 0);
        run(N'(7), 1'b0, N'(4), N'(2), 0);
        run(N'(3), 1'b0, N'(1), N'(1), 0);

        // Moduli near R.
        mm = '1;
        run(mm, 1'b0, N'(1), N'(1), 0);
        mm = '0; mm[N-1] = 1'b1; mm[0] = 1'b1;
        rr = '1; rr[N-1] = 1'b0;
        run(mm, 1'b0, rr, N'(4), 0);

        // Rejected moduli, after a valid run so the outputs were non-zero.
        mm = '1; mm[0] = 1'b0;
        run(mm, 1'b1, '0, '0, 0);
        run(N'(13), 1'b0, N'(9), N'(3), 0);
        run(N'(1), 1'b1, '0, '0, 0);

        // Start while busy is ignored and m is not re-latched.
        run(N'(13), 1'b0, N'(9), N'(3), 100);

        // Start held high: restarts every 2N+2 cycles.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.modulus = N'(7);
        sb_q.push_back('{1'b0, N'(4), N'(2)});
        sb_q.push_back('{1'b0, N'(4), N'(2)});
        cyc = 0;
        @(negedge clk);
        while (!bus.done && cyc < 2 * N + 20) begin @(negedge clk); cyc++; end
        cyc = 0;
        @(negedge clk);
        while (!bus.done && cyc < 2 * N + 20) begin @(negedge clk); cyc++; end
        bus.start = 1'b0;
        chk("restart_period", N'(cyc + 1), N'(2 * N + 2));
        repeat (3) @(negedge clk);
        chk("idle_after_restart", N'(bus.busy), N'(0));

        // Asynchronous reset mid-run, off the clock edge.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.modulus = N'(13);
        sb_q.push_back('{1'b0, N'(9), N'(3)});
        @(negedge clk);
        bus.start = 1'b0;
        repeat (599) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", N'(bus.busy), N'(0));
        chk("arst_done", N'(bus.done), N'(0));
        chk("arst_error", N'(bus.error), N'(0));
        chk("arst_rmodm", bus.rmodm, '0);
        chk("arst_r2", bus.rsquaredmodm, '0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run(N'(11), 1'b0, N'(4), N'(5), 0);

        // Random odd moduli against the remainder model.
        for (int i = 0; i < 6; i++) begin
            for (int w = 0; w < N / 32; w++) mm[w*32 +: 32] = $urandom();
            mm[0] = 1'b1;
            if (i % 2 == 1) mm[N-1:N/2] = '0;
            run(mm, 1'b0, pow2mod(mm, N), pow2mod(mm, 2 * N), 0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", N'(sb_q.size()), N'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/montgomery_precompute.md
# montgomery_precompute

Computes the Montgomery domain constants R mod m and R² mod m (R = 2^N) for a given odd modulus m. It sits directly upstream of the exponentiation stage and drives that stage's `Rmodm` and `Rsquaredmodm` operands. It uses iterative modular doubling, one doubling per clock, and needs no multiplier. The results are held stable until the next start, so the downstream stage can sample them at any time after `done`.

## Interface
- `N`, default 512: operand width in bits; R = 2^N.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  single-cycle request; sampled only in IDLE.
- `modulus`  input  N  modulus m; latched on the accepted `start`.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse at the end of a computation, including an error termination.
- `error`  output  1  valid with `done`; 1 = modulus rejected (m even or m == 1).
- `Rmodm`  output  N  2^N mod m.
- `Rsquaredmodm`  output  N  2^(2N) mod m.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start` = 1 latches `modulus` into m_reg.
  - If m[0] == 0 or m == 1: go to DONE with the `error` flag set; `Rmodm` and `Rsquaredmodm` are driven to 0.
  - Otherwise: v <= 1, cnt <= 0, clear the `error` flag, go to RUN.
- RUN, every cycle:
  - t = {v, 1'b0}, N+1 bits.
  - v <= (t >= m) ? t − m : t.
  - cnt <= cnt + 1.
- Invariant: v < m always holds, so a single conditional subtract is sufficient. The compare and subtract are N+1 bits wide, and the result is truncated to N bits.
- Result capture:
  - When the doubling with cnt == N−1 completes, the new v is captured into `Rmodm`.
  - When the doubling with cnt == 2N−1 completes, the new v is captured into `Rsquaredmodm` and the block goes to DONE.
- cnt width is clog2(2N)+1 bits.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `busy` = (state != IDLE).
- `start` while `busy` is ignored, and `modulus` is not re-latched.
- `Rmodm`, `Rsquaredmodm` and `error` hold their values until the next accepted `start`.
  - `Rmodm` is written mid-run, so its value is valid only once `done` has been seen.

## Timing
- Reset (asynchronous, any state):
  - state = IDLE.
  - `busy`, `done` and `error` = 0.
  - `Rmodm`, `Rsquaredmodm`, v, cnt and m_reg = 0.
  - A computation in progress is abandoned; no `done` is produced.
- Cycle numbering: the edge that samples `start` is E0.
- Valid modulus:
  - RUN occupies edges E1..E2N.
  - `Rmodm` is updated at E_N.
  - `Rsquaredmodm` is updated at E2N.
  - `done` is high in the cycle after E2N, giving a total latency of 2N+1 cycles (1025 for N = 512).
  - `busy` is high from after E0 through the `done` cycle.
- Invalid modulus: `done` and `error` are high in the cycle after E0 (latency 1); `busy` is high for that cycle only.
- `start` is accepted again in the first cycle after `done`. Back-to-back runs have a one-cycle gap in IDLE.
- `start` held high continuously restarts a computation every 2N+2 cycles.

## Test plan
- Small modulus, N = 512, m = 13, pulse `start`:
  - `done` arrives 1025 cycles later with `error` = 0, `Rmodm` = 9, `Rsquaredmodm` = 3.
- Wide modulus near R, N = 512:
  - m = 2^512−1 → `Rmodm` = 1, `Rsquaredmodm` = 1.
  - m = 2^511+1 → `Rmodm` = 2^511−1, `Rsquaredmodm` = 4.
- Rejected moduli:
  - m = 0x…FE (even) → `done` and `error` high 1 cycle after `start`; both result outputs = 0.
  - Same response for m = 1.
- Start while busy:
  - Pulse `start` with m = 13.
  - At cycle 100, pulse `start` with m = 11.
  - Required: the second start is ignored; results are still 9 and 3 at cycle 1025.
- Reset mid-run:
  - Assert `reset` asynchronously (off a clock edge) at cycle 600.
  - Required: all outputs go to 0 immediately and no `done` appears.
  - A fresh start with m = 11 then gives 2^512 mod 11 = 4 and 2^1024 mod 11 = 5.
- Random regression:
  - 200 random odd m with N = 64 and N = 512.
  - Results are compared against a reference model computing pow(2, N, m) and pow(2, 2N, m).
  - `busy` and `done` cycle counts are checked exactly.
